// File: rtl/pe_seq_ctrl_pkg.sv
// pe_ctrl_pkg: shared types for the adder-tree PE sequencer.
//   state_t        - sequencer FSM states (IDLE/RUN/DRAIN)
//   PE_LAT_DEFAULT - default PE pipeline latency, accepting edge inclusive
//   tag_t          - per-beat tag carried alongside the PE pipeline
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PE_LAT_DEFAULT = 6;

  // fin: the beat closed a group; last: that group was the last of the job.
  typedef struct packed {
    logic fin;
    logic last;
  } tag_t;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: operand-beat handshake, PE control/sum and result stream.
//   src_valid/src_ready             - operand beat handshake from the feeders
//   pe_valid/pe_final/pe_acc_clr    - per-beat controls towards the PE
//   pe_sum                          - PE accumulator output
//   res_valid/res_ready/res_data/res_last - result stream to write-back
// slave: the sequencer's view; master: the surrounding environment's view.
interface pe_seq_ctrl_if #(
  parameter int OUT_BITS = 32
);
  logic                src_valid;
  logic                src_ready;
  logic                pe_valid;
  logic                pe_final;
  logic                pe_acc_clr;
  logic [OUT_BITS-1:0] pe_sum;
  logic                res_valid;
  logic                res_ready;
  logic [OUT_BITS-1:0] res_data;
  logic                res_last;

  modport master (
    output src_valid, pe_sum, res_ready,
    input  src_ready, pe_valid, pe_final, pe_acc_clr, res_valid, res_data, res_last
  );

  modport slave (
    input  src_valid, pe_sum, res_ready,
    output src_ready, pe_valid, pe_final, pe_acc_clr, res_valid, res_data, res_last
  );
endinterface

// File: rtl/pe_seq_ctrl_res_fifo.sv
// res_fifo: synchronous first-word-fall-through FIFO with registered flags.
//   push/push_data - write (dropped only if full and not popping)
//   pop/pop_data   - head is valid whenever empty is low; pop consumes it
//   empty/full     - registered status flags
// Push and pop in the same cycle are both honoured, also when full.
module res_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      cnt_r, cnt_nxt_s;
  logic             empty_r, full_r;
  logic             do_push_s, do_pop_s;

  assign do_pop_s  = pop & ~empty_r;
  assign do_push_s = push & (~full_r | do_pop_s);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      cnt_r   <= cnt_nxt_s;
      empty_r <= (cnt_nxt_s == {(AW+1){1'b0}});
      full_r  <= (cnt_nxt_s == FULL_CNT);
    end
  end

  // Storage array; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign pop_data = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign empty    = empty_r;
  assign full     = full_r;
endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequencer for one 8-lane adder-tree PE.
//   clk, reset            - clock, synchronous active-high reset
//   start, cfg_rounds/cfg_groups - job launch; rounds = beats per word (0 -> 1)
//   busy, done            - job in progress / one-cycle completion pulse
//   bus (slave)           - beat handshake, PE controls, PE sum, result stream
// Finished groups are tagged through a PE_LAT-deep delay line that mirrors the
// PE pipeline; when a tag falls out, pe_sum is captured into the result FIFO.
// A credit counter reserves a FIFO slot per final beat, so the FIFO cannot overflow.
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int OUT_BITS  = 32,
  parameter int CNT_BITS  = 16,
  parameter int PE_LAT    = PE_LAT_DEFAULT,
  parameter int RES_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_BITS-1:0] cfg_rounds,
  input  logic [CNT_BITS-1:0] cfg_groups,
  output logic                busy,
  output logic                done,
  pe_seq_ctrl_if.slave        bus
);
  localparam int                 CR_BITS     = $clog2(RES_DEPTH) + 1;
  localparam logic [CR_BITS-1:0] CREDIT_INIT = CR_BITS'(RES_DEPTH);
  localparam logic [CR_BITS-1:0] CR_ONE      = CR_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO   = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

  state_t              state_r, state_nxt_s;
  logic [CNT_BITS-1:0] rounds_r, groups_r, beat_cnt_r, grp_cnt_r;
  logic [CR_BITS-1:0]  credit_r;
  tag_t                tag_r [PE_LAT];
  logic                done_r, done_nxt_s, load_s;
  logic                final_beat_s, last_grp_s, accept_s, acc_final_s;
  logic                pop_s, push_s, res_empty_s, res_full_s;
  logic [OUT_BITS:0]   fifo_dout_s;

  // A final beat needs a reserved result slot; other beats never wait.
  assign final_beat_s   = (beat_cnt_r == rounds_r - CNT_ONE);
  assign last_grp_s     = (grp_cnt_r == groups_r - CNT_ONE);
  assign bus.src_ready  = (state_r == RUN) & (~final_beat_s | (credit_r != {CR_BITS{1'b0}}));
  assign accept_s       = bus.src_valid & bus.src_ready;
  assign acc_final_s    = accept_s & final_beat_s;
  assign bus.pe_valid   = accept_s;
  assign bus.pe_final   = acc_final_s;
  assign bus.pe_acc_clr = accept_s & (beat_cnt_r == CNT_ZERO);
  assign pop_s          = bus.res_valid & bus.res_ready;
  assign busy           = (state_r != IDLE);
  assign done           = done_r;

  // Next-state, job load and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_groups != CNT_ZERO) begin
            state_nxt_s = RUN;
            load_s      = 1'b1;
          end else begin
            done_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (acc_final_s && last_grp_s) state_nxt_s = DRAIN;
        else                           state_nxt_s = RUN;
      end
      DRAIN: begin
        if (pop_s && bus.res_last) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Job configuration latch and beat/group counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rounds_r   <= CNT_ONE;
      groups_r   <= CNT_ONE;
      beat_cnt_r <= CNT_ZERO;
      grp_cnt_r  <= CNT_ZERO;
    end else if (load_s) begin
      rounds_r   <= (cfg_rounds == CNT_ZERO) ? CNT_ONE : cfg_rounds;
      groups_r   <= cfg_groups;
      beat_cnt_r <= CNT_ZERO;
      grp_cnt_r  <= CNT_ZERO;
    end else if (accept_s) begin
      if (final_beat_s) begin
        beat_cnt_r <= CNT_ZERO;
        grp_cnt_r  <= grp_cnt_r + CNT_ONE;
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_ONE;
      end
    end
  end

  // Result-slot credit: taken by a final beat, returned by a result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_r <= CREDIT_INIT;
    end else begin
      case ({acc_final_s, pop_s})
        2'b10:   credit_r <= credit_r - CR_ONE;
        2'b01:   credit_r <= credit_r + CR_ONE;
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Tag delay line aligned with the PE pipeline; bubbles shift in as zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PE_LAT; i++) tag_r[i] <= '{fin: 1'b0, last: 1'b0};
    end else begin
      tag_r[0] <= '{fin: acc_final_s, last: acc_final_s & last_grp_s};
      for (int i = 1; i < PE_LAT; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  // Credit already guarantees space; the full check is a second line of defence.
  assign push_s = tag_r[PE_LAT-1].fin & (~res_full_s | pop_s);

  res_fifo #(
    .WIDTH (OUT_BITS + 1),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({tag_r[PE_LAT-1].last, bus.pe_sum}),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .empty     (res_empty_s),
    .full      (res_full_s)
  );

  assign bus.res_valid = ~res_empty_s;
  assign bus.res_data  = fifo_dout_s[OUT_BITS-1:0];
  assign bus.res_last  = fifo_dout_s[OUT_BITS];
endmodule
